// File: rtl/imm_gen_exe.sv
// rtl/imm_gen_exe.sv - execute-stage immediate rebuild with two-entry elastic buffer
module imm_gen_exe #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_INSTR = 32'h00000013
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_imm_sel,
  input  logic [XLEN-1:0] in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_imm,
  output logic            out_illegal
);

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   out_instr_d, out_imm_d;
  logic              out_illegal_d;
  logic [XLEN-1:0]   skid_instr_q, skid_instr_d, skid_imm_q, skid_imm_d;
  logic              skid_illegal_q, skid_illegal_d;
  logic [XLEN-1:0]   new_imm;
  logic              new_illegal;
  logic              accept, pop;

  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Immediate is rebuilt from the raw instruction before it is stored anywhere
  always_comb begin
    new_imm     = '0;
    new_illegal = 1'b0;
    case (in_imm_sel)
      4'd0: new_imm = '0;
      4'd1: new_imm = {{20{in_instr[31]}}, in_instr[31:20]};
      4'd2: new_imm = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      4'd3: new_imm = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                       in_instr[30:25], in_instr[11:8], 1'b0};
      4'd4: new_imm = {in_instr[31:12], 12'h000};
      4'd5: new_imm = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                       in_instr[20], in_instr[30:21], 1'b0};
      default: new_illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    out_instr_d    = out_instr;
    out_imm_d      = out_imm;
    out_illegal_d  = out_illegal;
    skid_instr_d   = skid_instr_q;
    skid_imm_d     = skid_imm_q;
    skid_illegal_d = skid_illegal_q;
    if (flush) begin
      state_d       = ST_EMPTY;
      out_instr_d   = RESET_INSTR;
      out_imm_d     = '0;
      out_illegal_d = 1'b0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d       = ST_ONE;
            out_instr_d   = in_instr;
            out_imm_d     = new_imm;
            out_illegal_d = new_illegal;
          end
        end
        ST_ONE: begin
          if (accept && pop) begin
            out_instr_d   = in_instr;
            out_imm_d     = new_imm;
            out_illegal_d = new_illegal;
          end else if (accept) begin
            state_d        = ST_TWO;
            skid_instr_d   = in_instr;
            skid_imm_d     = new_imm;
            skid_illegal_d = new_illegal;
          end else if (pop) begin
            // Going empty: present the reset NOP again
            state_d       = ST_EMPTY;
            out_instr_d   = RESET_INSTR;
            out_imm_d     = '0;
            out_illegal_d = 1'b0;
          end
        end
        ST_TWO: begin
          if (pop) begin
            state_d       = ST_ONE;
            out_instr_d   = skid_instr_q;
            out_imm_d     = skid_imm_q;
            out_illegal_d = skid_illegal_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_EMPTY;
      in_ready       <= 1'b1;
      out_instr      <= RESET_INSTR;
      out_imm        <= '0;
      out_illegal    <= 1'b0;
      skid_instr_q   <= '0;
      skid_imm_q     <= '0;
      skid_illegal_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      in_ready       <= (state_d != ST_TWO);
      out_instr      <= out_instr_d;
      out_imm        <= out_imm_d;
      out_illegal    <= out_illegal_d;
      skid_instr_q   <= skid_instr_d;
      skid_imm_q     <= skid_imm_d;
      skid_illegal_q <= skid_illegal_d;
    end
  end

endmodule
